// File: rtl/pc_reg_ext.sv
// Program-counter register for the fetch stage: reset vector, sequential increment,
// flush/branch redirects, a pending branch target held across stalls, and a misaligned-fetch flag.
module pc_reg_ext #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned PC_INC    = 4,
    parameter int unsigned STALL_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   new_pc,
    input  logic                branch_flag_i,
    input  logic [ADDR_W-1:0]   branch_target_address_i,
    output logic [ADDR_W-1:0]   pc,
    output logic                ce,
    output logic                pc_misaligned
);

    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] INC_VAL = ADDR_W'(PC_INC);

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    logic [ADDR_W-1:0] pc_n;
    logic              ce_n;
    logic              mis_n;
    logic              pend_valid_n;
    logic [ADDR_W-1:0] pend_target_n;

    // Only stall[0] gates the PC; the upper stages' bits are intentionally ignored.
    logic unused_stall;
    assign unused_stall = ^stall;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RST_PC;
            ce            <= 1'b0;
            pc_misaligned <= 1'b0;
            pend_valid    <= 1'b0;
            pend_target   <= '0;
        end else begin
            pc            <= pc_n;
            ce            <= ce_n;
            pc_misaligned <= mis_n;
            pend_valid    <= pend_valid_n;
            pend_target   <= pend_target_n;
        end
    end

    // Next-pc selection: flush > stall > live branch > pending branch > increment.
    always_comb begin
        pc_n          = pc;
        ce_n          = 1'b1;
        mis_n         = pc_misaligned;
        pend_valid_n  = pend_valid;
        pend_target_n = pend_target;

        if (!ce) begin
            pc_n          = RST_PC;
            mis_n         = 1'b0;
            pend_valid_n  = 1'b0;
            pend_target_n = '0;
        end else if (flush) begin
            pc_n         = new_pc;
            pend_valid_n = 1'b0;
            mis_n        = |new_pc[1:0];
        end else if (stall[0]) begin
            if (branch_flag_i) begin
                pend_valid_n  = 1'b1;
                pend_target_n = branch_target_address_i;
            end
        end else if (branch_flag_i) begin
            pc_n         = branch_target_address_i;
            pend_valid_n = 1'b0;
            mis_n        = |branch_target_address_i[1:0];
        end else if (pend_valid) begin
            pc_n         = pend_target;
            pend_valid_n = 1'b0;
            mis_n        = |pend_target[1:0];
        end else begin
            pc_n  = pc + INC_VAL;
            mis_n = |pc_n[1:0];
        end
    end

endmodule

// File: tb/tb_pc_reg_ext.sv
// Directed bench for pc_reg_ext: a default 32-bit instance and a 16-bit instance
// with reset vector 16'hFFF8 for the wrap and misalignment cases.
module tb_pc_reg_ext;

    logic        clk;
    logic        rst;
    logic        rst16;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] bta;
    logic [15:0] new_pc16;
    logic [15:0] bta16;

    logic [31:0] pc;
    logic        ce;
    logic        mis;
    logic [15:0] pc16;
    logic        ce16;
    logic        mis16;

    int n_pass;
    int n_total;

    pc_reg_ext dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag_i(branch_flag), .branch_target_address_i(bta),
        .pc(pc), .ce(ce), .pc_misaligned(mis)
    );

    pc_reg_ext #(.ADDR_W(16), .RESET_VEC(32'h0000_FFF8), .PC_INC(4), .STALL_W(6)) dut16 (
        .clk(clk), .rst(rst16), .stall(stall), .flush(flush), .new_pc(new_pc16),
        .branch_flag_i(branch_flag), .branch_target_address_i(bta16),
        .pc(pc16), .ce(ce16), .pc_misaligned(mis16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (ce !== 1'b0 || pc !== 32'h0) $display("FAIL reset_hold[%0d]: ce=%b pc=%h, want ce=0 pc=00000000", i, ce, pc);
            else n_pass++;
        end
        n_total++;
        if (mis !== 1'b0) $display("FAIL reset_mis: got %b want 0", mis);
        else n_pass++;
        rst = 1'b0;
        step();
        n_total++;
        if (ce !== 1'b1 || pc !== 32'h0) $display("FAIL enable_edge: ce=%b pc=%h, want ce=1 pc=00000000", ce, pc);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_total++;
            if (pc !== 32'(i * 4)) $display("FAIL seq_inc[%0d]: got %h want %h", i, pc, 32'(i * 4));
            else n_pass++;
        end
    endtask

    task automatic test_branch_stalled();
        step();
        n_total++;
        if (pc !== 32'h10) $display("FAIL pre_stall_pc: got %h want 00000010", pc);
        else n_pass++;
        stall = 6'b000011; branch_flag = 1'b1; bta = 32'h100;
        step();
        branch_flag = 1'b0; bta = 32'h0;
        n_total++;
        if (pc !== 32'h10) $display("FAIL stall_hold0: got %h want 00000010", pc);
        else n_pass++;
        for (int i = 1; i < 3; i++) begin
            step();
            n_total++;
            if (pc !== 32'h10) $display("FAIL stall_hold%0d: got %h want 00000010", i, pc);
            else n_pass++;
        end
        stall = 6'b0;
        step();
        n_total++;
        if (pc !== 32'h100) $display("FAIL pend_redirect: got %h want 00000100", pc);
        else n_pass++;
        step();
        n_total++;
        if (pc !== 32'h104) $display("FAIL pend_after: got %h want 00000104", pc);
        else n_pass++;
    endtask

    task automatic test_flush();
        stall = 6'b000001; branch_flag = 1'b1; bta = 32'h300;
        step();
        n_total++;
        if (pc !== 32'h104) $display("FAIL flush_prep_hold: got %h want 00000104", pc);
        else n_pass++;
        bta = 32'h200; flush = 1'b1; new_pc = 32'h180;
        step();
        flush = 1'b0; branch_flag = 1'b0; new_pc = 32'h0; bta = 32'h0;
        n_total++;
        if (pc !== 32'h180) $display("FAIL flush_pc: got %h want 00000180", pc);
        else n_pass++;
        step();
        n_total++;
        if (pc !== 32'h180) $display("FAIL flush_stall_hold: got %h want 00000180", pc);
        else n_pass++;
        stall = 6'b0;
        step();
        n_total++;
        if (pc !== 32'h184) $display("FAIL flush_pend_cleared: got %h want 00000184", pc);
        else n_pass++;
    endtask

    task automatic test_overwrite();
        stall = 6'b000001; branch_flag = 1'b1; bta = 32'h40;
        step();
        bta = 32'h80;
        step();
        branch_flag = 1'b0; bta = 32'h0; stall = 6'b0;
        step();
        n_total++;
        if (pc !== 32'h80) $display("FAIL overwrite_pc: got %h want 00000080", pc);
        else n_pass++;
        step();
        n_total++;
        if (pc !== 32'h84) $display("FAIL overwrite_after: got %h want 00000084", pc);
        else n_pass++;
    endtask

    task automatic test_live_over_pending();
        stall = 6'b000001; branch_flag = 1'b1; bta = 32'h40;
        step();
        stall = 6'b0; bta = 32'h90;
        step();
        branch_flag = 1'b0; bta = 32'h0;
        n_total++;
        if (pc !== 32'h90) $display("FAIL live_branch_pc: got %h want 00000090", pc);
        else n_pass++;
        step();
        n_total++;
        if (pc !== 32'h94) $display("FAIL live_pend_dropped: got %h want 00000094", pc);
        else n_pass++;
    endtask

    task automatic test_flush_misaligned();
        flush = 1'b1; new_pc = 32'h181;
        step();
        flush = 1'b0; new_pc = 32'h0;
        n_total++;
        if (pc !== 32'h181 || mis !== 1'b1) $display("FAIL flush_mis: pc=%h mis=%b, want pc=00000181 mis=1", pc, mis);
        else n_pass++;
        step();
        n_total++;
        if (pc !== 32'h185 || mis !== 1'b1) $display("FAIL inc_mis: pc=%h mis=%b, want pc=00000185 mis=1", pc, mis);
        else n_pass++;
        branch_flag = 1'b1; bta = 32'h1000;
        step();
        branch_flag = 1'b0; bta = 32'h0;
        n_total++;
        if (pc !== 32'h1000 || mis !== 1'b0) $display("FAIL realign: pc=%h mis=%b, want pc=00001000 mis=0", pc, mis);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        stall = 6'b000001; branch_flag = 1'b1; bta = 32'h500;
        step();
        branch_flag = 1'b0; bta = 32'h0;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (ce !== 1'b0 || pc !== 32'h0 || mis !== 1'b0) $display("FAIL async_reset: ce=%b pc=%h mis=%b, want ce=0 pc=00000000 mis=0", ce, pc, mis);
        else n_pass++;
        stall = 6'b0;
        step();
        rst = 1'b0;
        step();
        n_total++;
        if (ce !== 1'b1 || pc !== 32'h0) $display("FAIL reenable: ce=%b pc=%h, want ce=1 pc=00000000", ce, pc);
        else n_pass++;
        step();
        n_total++;
        if (pc !== 32'h4) $display("FAIL no_stale_pend: got %h want 00000004", pc);
        else n_pass++;
    endtask

    task automatic test_wrap_misalign16();
        n_total++;
        if (ce16 !== 1'b0 || pc16 !== 16'hFFF8) $display("FAIL reset16: ce=%b pc=%h, want ce=0 pc=fff8", ce16, pc16);
        else n_pass++;
        rst16 = 1'b0;
        step();
        n_total++;
        if (ce16 !== 1'b1 || pc16 !== 16'hFFF8) $display("FAIL enable16: ce=%b pc=%h, want ce=1 pc=fff8", ce16, pc16);
        else n_pass++;
        step();
        n_total++;
        if (pc16 !== 16'hFFFC) $display("FAIL seq16_fffc: got %h want fffc", pc16);
        else n_pass++;
        step();
        n_total++;
        if (pc16 !== 16'h0000 || mis16 !== 1'b0) $display("FAIL wrap16: pc=%h mis=%b, want pc=0000 mis=0", pc16, mis16);
        else n_pass++;
        branch_flag = 1'b1; bta16 = 16'h0102;
        step();
        branch_flag = 1'b0;
        n_total++;
        if (pc16 !== 16'h0102 || mis16 !== 1'b1) $display("FAIL mis16_set: pc=%h mis=%b, want pc=0102 mis=1", pc16, mis16);
        else n_pass++;
        stall = 6'b000001;
        step();
        n_total++;
        if (pc16 !== 16'h0102 || mis16 !== 1'b1) $display("FAIL mis16_hold: pc=%h mis=%b, want pc=0102 mis=1", pc16, mis16);
        else n_pass++;
        stall = 6'b0; branch_flag = 1'b1; bta16 = 16'h0200;
        step();
        branch_flag = 1'b0; bta16 = 16'h0;
        n_total++;
        if (pc16 !== 16'h0200 || mis16 !== 1'b0) $display("FAIL mis16_clear: pc=%h mis=%b, want pc=0200 mis=0", pc16, mis16);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; rst16 = 1'b1;
        stall = 6'b0; flush = 1'b0; new_pc = 32'h0; branch_flag = 1'b0; bta = 32'h0;
        new_pc16 = 16'h0; bta16 = 16'h0;
        test_reset();
        test_branch_stalled();
        test_flush();
        test_overwrite();
        test_live_over_pending();
        test_flush_misaligned();
        test_async_reset();
        test_wrap_misalign16();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_reg_ext.md
Name: pc_reg_ext

Overview:
Parametrised program-counter register for the OpenMIPS fetch stage, replacing the fixed-width, increment-only PC.
- Adds a configurable reset vector, increment and stall-vector width.
- Adds redirect sources: pipeline flush/exception target and branch target.
- Holds a pending branch target captured while fetch is stalled.
- Flags misaligned fetch addresses.
- Feeds the instruction ROM (pc, ce) and the IF/ID register.

Parameters:
ADDR_W, 32, width of pc and all target addresses
RESET_VEC, 32'h00000000, pc value while fetch is disabled (truncated to ADDR_W)
PC_INC, 4, sequential increment added to pc
STALL_W, 6, width of stall vector; bit 0 gates the PC

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  STALL_W  pipeline stall vector from ctrl; only stall[0] used here
flush  in  1  exception/ERET flush from ctrl, single-cycle pulse
new_pc  in  ADDR_W  redirect target accompanying flush
branch_flag_i  in  1  taken branch/jump resolved in ID
branch_target_address_i  in  ADDR_W  branch/jump target
pc  out  ADDR_W  current fetch address
ce  out  1  instruction memory chip enable
pc_misaligned  out  1  registered flag: pc[1:0] != 0 while ce = 1

Behaviour:
- Reset, asynchronous while rst = 1:
  - ce = 0, pc = RESET_VEC, pc_misaligned = 0.
  - pend_valid = 0, pend_target = 0.
- Enable sequencing:
  - ce is set to 1 on the first rising edge with rst = 0.
  - On that same edge pc keeps RESET_VEC, because ce was 0.
  - Net effect: the first fetch is RESET_VEC, and ce rises one cycle after reset release.
- Whenever ce = 0 at a clock edge:
  - pc <= RESET_VEC and the pending branch is cleared.
  - All other inputs are ignored.
- With ce = 1, next-pc priority per rising edge, highest first:
  1. flush = 1: pc <= new_pc and pend_valid <= 0. This ignores stall and branch.
  2. stall[0] = 1: pc holds.
     - If branch_flag_i = 1, then pend_target <= branch_target_address_i and pend_valid <= 1.
     - A newer branch overwrites an older pending target.
  3. branch_flag_i = 1, no stall: pc <= branch_target_address_i and pend_valid <= 0. A live branch beats a pending one.
  4. pend_valid = 1, no stall: pc <= pend_target and pend_valid <= 0.
  5. Otherwise: pc <= pc + PC_INC, modulo 2^ADDR_W. Wrap-around from all-ones is silent.
- pc_misaligned is registered with pc:
  - Equals (next pc [1:0] != 0) whenever pc is loaded with ce = 1.
  - Holds while pc holds.
  - Is 0 when ce = 0.
  - The block does not trap; the exception unit consumes the flag.
- No combinational path from any input to any output.
- Reset asserted mid-operation immediately forces all reset values, including discarding any pending branch.

Test Plan:
- Reset release, no stall, defaults:
  - rst high 3 cycles, then low.
  - Required: ce = 0 and pc = 0 during reset; ce = 1 after 1st edge with pc = 0.
  - Required: pc = 4, 8, 12 on the following edges.
- Branch while stalled:
  - At pc = 0x10, stall = 6'b000011 for 3 cycles; branch_flag_i pulsed in the 1st stalled cycle with target 0x100.
  - Required: pc stays 0x10 during the stall, becomes 0x100 on the first unstalled edge, then 0x104.
- Flush overrides stall and branch:
  - stall[0] = 1, branch_flag_i = 1 (target 0x200), flush = 1 (new_pc 0x180), all together, with a pending target already held.
  - Required: pc = 0x180 next edge, pending cleared, then 0x184 once the stall drops.
- Overwrite and live-over-pending:
  - Two branches during one stall (targets 0x40 then 0x80). Required: pc = 0x80 after release.
  - Separately, a pending 0x40 plus a live unstalled branch to 0x90. Required: pc = 0x90.
- Misalignment and wrap, ADDR_W = 16, RESET_VEC = 16'hFFF8:
  - pc sequence FFF8, FFFC, 0000.
  - Branch to 0x0102 gives pc_misaligned = 1 on the same edge that pc = 0x0102, and the flag clears after a branch to 0x0200.
- Asynchronous reset mid-run:
  - Assert rst between clock edges while a branch is pending.
  - Required: ce = 0 and pc = RESET_VEC immediately, without waiting for an edge.
  - Required: no pending redirect after re-enable; pc restarts RESET_VEC, +4.
